async_handshake_source: RTL and testbench



---
 rtl/async_handshake_pkg.sv | 32 +++
 rtl/async_handshake_source_if.sv | 54 +++++
 rtl/ack_sync_shift_reg.sv | 45 ++++
 rtl/async_handshake_source.sv | 164 ++++++++++++++++
 tb/tb_async_handshake_source.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/async_handshake_pkg.sv
// -----------------------------------------------------------------------------
// async_handshake_pkg
//
// Shared types and constants for the 2-phase (toggle) clock-domain-crossing
// handshake source.
//
// Contents:
//   DEFAULT_WIDTH       default payload width in bits
//   DEFAULT_SYNC_DEPTH  default number of flops on the io_ack synchronizer
//   state_e             source FSM states (SETTLE, IDLE, WAIT_ACK)
//   settle_cnt_width()  width of a counter that must reach SYNC_DEPTH
// -----------------------------------------------------------------------------
package async_handshake_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_SYNC_DEPTH = 3;

    // SETTLE : after reset, wait for the ack synchronizer to flush
    // IDLE   : ready to accept a word
    // WAIT_ACK: word launched, waiting for the synchronized ack toggle
    typedef enum logic [1:0] {
        SETTLE   = 2'd0,
        IDLE     = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    // The settle counter counts 0..sync_depth inclusive.
    function automatic int settle_cnt_width(input int sync_depth);
        return $clog2(sync_depth + 1);
    endfunction

endpackage : async_handshake_pkg

// File: rtl/async_handshake_source_if.sv
// -----------------------------------------------------------------------------
// async_handshake_source_if
//
// Bundles the producer-side enqueue port and the crossing-side req/data/ack
// signals of one toggle handshake source.
//
// Signals:
//   io_enq_ready  source can accept a word this cycle
//   io_enq_valid  producer offers io_enq_bits
//   io_enq_bits   payload offered by the producer
//   io_req        request toggle towards the sink
//   io_data       payload towards the sink, stable while a transfer is open
//   io_ack        acknowledge toggle from the sink (asynchronous)
//   io_busy       transfer outstanding or settling after reset
//
// Modports:
//   master  the handshake source (drives ready/req/data/busy)
//   slave   the surrounding producer and sink (drive valid/bits/ack)
// -----------------------------------------------------------------------------
interface async_handshake_source_if
    import async_handshake_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             io_enq_ready;
    logic             io_enq_valid;
    logic [WIDTH-1:0] io_enq_bits;
    logic             io_req;
    logic [WIDTH-1:0] io_data;
    logic             io_ack;
    logic             io_busy;

    modport master (
        output io_enq_ready,
        input  io_enq_valid,
        input  io_enq_bits,
        output io_req,
        output io_data,
        input  io_ack,
        output io_busy
    );

    modport slave (
        input  io_enq_ready,
        output io_enq_valid,
        output io_enq_bits,
        input  io_req,
        input  io_data,
        output io_ack,
        input  io_busy
    );

endinterface : async_handshake_source_if

// File: rtl/ack_sync_shift_reg.sv
// -----------------------------------------------------------------------------
// ack_sync_shift_reg
//
// Multi-flop synchronizer for the asynchronous acknowledge toggle. This is
// the only consumer of io_ack in the source domain; CDC tooling should treat
// sync_q as the synchronizer chain.
//
// Ports:
//   clock  source-domain clock
//   reset  synchronous, active-high reset (clears every stage)
//   d_i    asynchronous input (io_ack)
//   q_o    synchronized output, SYNC_DEPTH clock edges after d_i
// -----------------------------------------------------------------------------
module ack_sync_shift_reg
    import async_handshake_pkg::*;
#(
    parameter int SYNC_DEPTH = DEFAULT_SYNC_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    (* async_reg = "true" *) logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] sync_d;

    // Stage 0 samples the asynchronous input; each later stage resolves
    // metastability of the one before it.
    assign sync_d = {sync_q[SYNC_DEPTH-2:0], d_i};

    // NOTE: every flop is written with <= so all stages sample the old
    // value of their predecessor on the same edge; with = the chain would
    // collapse into a single stage in simulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_DEPTH-1];

endmodule : ack_sync_shift_reg

// File: rtl/async_handshake_source.sv
// -----------------------------------------------------------------------------
// async_handshake_source
//
// Transmit end of a 2-phase (toggle) clock-domain-crossing handshake.
// A word accepted on the enqueue port is registered onto io_data and
// announced by inverting io_req. The source then waits until the
// synchronized io_ack equals io_req before accepting the next word.
//
// Ports:
//   clock  source-domain clock
//   reset  synchronous, active-high reset
//   bus    async_handshake_source_if.master:
//            io_enq_ready/io_enq_valid/io_enq_bits  enqueue port
//            io_req/io_data                         towards the sink
//            io_ack                                 from the sink (async)
//            io_busy                                transfer open / settling
//
// Every output is either a flop or a decode of the state register, so there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module async_handshake_source
    import async_handshake_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SYNC_DEPTH = DEFAULT_SYNC_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    async_handshake_source_if.master  bus
);

    localparam int CntW = settle_cnt_width(SYNC_DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("async_handshake_source: WIDTH must be >= 1");
    end
    if (SYNC_DEPTH < 2) begin : g_bad_depth
        $error("async_handshake_source: SYNC_DEPTH must be >= 2");
    end

    // ---------------------------------------------------------------------
    // Acknowledge synchronizer
    // ---------------------------------------------------------------------
    logic ack_s;

    ack_sync_shift_reg #(
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_ack_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (bus.io_ack),
        .q_o   (ack_s)
    );

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q,   cnt_d;
    logic             req_q,   req_d;
    logic [WIDTH-1:0] data_q,  data_d;
    // Sticky: ack toggled while no transfer was outstanding. Observed only
    // by assertions; it never alters behaviour.
    logic             err_q,   err_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold value before the case so that no
        // path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            SETTLE: begin
                // Stay here until whatever the synchronizer held before
                // reset has been shifted out, so a stale ack cannot be
                // mistaken for a completion.
                if (cnt_q == CntW'(SYNC_DEPTH)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            IDLE: begin
                // In IDLE the synchronized ack must already match req; a
                // difference means the sink toggled without a request.
                if (ack_s != req_q) begin
                    err_d = 1'b1;
                end
                if (bus.io_enq_valid) begin
                    data_d  = bus.io_enq_bits;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                // The sink echoes req back on ack; equality closes the
                // transfer. Acceptance reopens only from IDLE, one cycle on.
                if (ack_s == req_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------------
    always_comb begin
        bus.io_enq_ready = 1'b0;
        bus.io_busy      = 1'b1;
        if (state_q == IDLE) begin
            bus.io_enq_ready = 1'b1;
            bus.io_busy      = 1'b0;
        end
    end

    assign bus.io_req  = req_q;
    assign bus.io_data = data_q;

    // ---------------------------------------------------------------------
    // Assertions
    // ---------------------------------------------------------------------
    // The spurious-ack flag, once raised, is only cleared by reset.
    a_err_sticky: assert property (
        @(posedge clock) disable iff (reset) err_q |=> err_q
    );

    // req and data may only move on an accepted word in IDLE.
    a_req_only_on_fire: assert property (
        @(posedge clock) disable iff (reset)
        (state_q != IDLE) |=> (req_q == $past(req_q))
    );

endmodule : async_handshake_source

// File: tb/tb_async_handshake_source.sv
// -----------------------------------------------------------------------------
// tb_async_handshake_source
//
// Directed bench for async_handshake_source with WIDTH=32, SYNC_DEPTH=3.
// A sink model echoes io_req back on io_ack after SINK_DELAY cycles; an
// extra XOR term lets the bench inject ack glitches. Outputs are sampled on
// the falling edge, inputs are driven right after it.
// -----------------------------------------------------------------------------
module tb_async_handshake_source;
    import async_handshake_pkg::*;

    localparam int WIDTH      = DEFAULT_WIDTH;
    localparam int SYNC_DEPTH = 3;
    localparam int SINK_DELAY = 5;
    // fire -> sink echo -> synchronizer -> back to IDLE
    localparam int ACCEPT_GAP = SINK_DELAY + SYNC_DEPTH + 1;

    logic clock      = 1'b0;
    logic reset      = 1'b1;
    logic sink_rst   = 1'b1;
    logic ack_glitch = 1'b0;
    logic [SINK_DELAY-1:0] sink_sh = '0;

    int n_assert = 0;
    int n_fail   = 0;

    async_handshake_source_if #(.WIDTH(WIDTH)) bus ();

    async_handshake_source #(
        .WIDTH      (WIDTH),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Sink model: io_ack follows io_req SINK_DELAY cycles later.
    always @(posedge clock) begin
        if (sink_rst) sink_sh <= '0;
        else          sink_sh <= {sink_sh[SINK_DELAY-2:0], bus.io_req};
    end
    assign bus.io_ack = sink_sh[SINK_DELAY-1] ^ ack_glitch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Counts falling edges until io_enq_ready is seen high (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (bus.io_enq_ready !== 1'b1 && n < 64) begin
            @(negedge clock);
            n++;
        end
    endtask

    // Source and sink resets must always be asserted together.
    always @(posedge clock) check_bit("reset_pair", sink_rst, reset);

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic exp_req;
        logic [31:0] prev;
        logic [31:0] words [4];
        words[0] = 32'h0000_0001;
        words[1] = 32'h0000_0002;
        words[2] = 32'h0000_0003;
        words[3] = 32'h0000_0004;

        bus.io_enq_valid = 1'b0;
        bus.io_enq_bits  = '0;

        // ---- reset for two edges, then settle --------------------------
        cyc(); cyc();
        check_bit("rst_ready", bus.io_enq_ready, 1'b0);
        check_bit("rst_busy",  bus.io_busy,      1'b1);
        check_bit("rst_req",   bus.io_req,       1'b0);
        check    ("rst_data",  bus.io_data,      32'h0);
        reset = 1'b0; sink_rst = 1'b0;
        for (int i = 1; i <= SYNC_DEPTH; i++) begin
            cyc();
            check_bit("settle_ready", bus.io_enq_ready, 1'b0);
            check_bit("settle_req",   bus.io_req,       1'b0);
            check    ("settle_data",  bus.io_data,      32'h0);
        end
        cyc();
        check_bit("idle_ready", bus.io_enq_ready, 1'b1);
        check_bit("idle_busy",  bus.io_busy,      1'b0);

        // ---- first word, bits changed while waiting --------------------
        bus.io_enq_valid = 1'b1;
        bus.io_enq_bits  = 32'hDEAD_BEEF;
        cyc();
        check_bit("fire1_req",   bus.io_req,       1'b1);
        check    ("fire1_data",  bus.io_data,      32'hDEAD_BEEF);
        check_bit("fire1_ready", bus.io_enq_ready, 1'b0);
        check_bit("fire1_busy",  bus.io_busy,      1'b1);
        bus.io_enq_bits = 32'hFFFF_FFFF;          // valid stays high
        wait_ready(n);
        check("gap1",          n,           ACCEPT_GAP);
        check("hold1_data",    bus.io_data, 32'hDEAD_BEEF);
        cyc();
        check_bit("fire2_req", bus.io_req,  1'b0);
        check    ("fire2_data",bus.io_data, 32'hFFFF_FFFF);

        // ---- valid held high across several words ----------------------
        exp_req = 1'b0;
        prev    = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            bus.io_enq_bits = words[i];
            wait_ready(n);
            check("gap_seq",      n,           ACCEPT_GAP);
            check("seq_hold",     bus.io_data, prev);
            cyc();
            exp_req = ~exp_req;
            check_bit("seq_req",  bus.io_req,  exp_req);
            check    ("seq_data", bus.io_data, words[i]);
            prev = words[i];
        end
        bus.io_enq_valid = 1'b0;
        wait_ready(n);
        check("gap_last", n, ACCEPT_GAP);

        // ---- spurious ack toggle while idle ----------------------------
        check_bit("err_before", dut.err_q, 1'b0);
        ack_glitch = 1'b1;
        cyc();
        ack_glitch = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check_bit("spur_ready", bus.io_enq_ready, 1'b1);
            check_bit("spur_busy",  bus.io_busy,      1'b0);
            check_bit("spur_req",   bus.io_req,       1'b0);
            check    ("spur_data",  bus.io_data,      32'h4);
        end
        check_bit("err_set", dut.err_q, 1'b1);

        // ---- reset two cycles after a fire -----------------------------
        bus.io_enq_valid = 1'b1;
        bus.io_enq_bits  = 32'h0000_0055;
        cyc();
        check_bit("fire55_req",  bus.io_req,  1'b1);
        check    ("fire55_data", bus.io_data, 32'h55);
        bus.io_enq_valid = 1'b0;
        cyc();
        reset = 1'b1; sink_rst = 1'b1;
        cyc();
        check_bit("mrst_req",   bus.io_req,       1'b0);
        check    ("mrst_data",  bus.io_data,      32'h0);
        check_bit("mrst_ready", bus.io_enq_ready, 1'b0);
        check_bit("mrst_busy",  bus.io_busy,      1'b1);
        check_bit("mrst_err",   dut.err_q,        1'b0);
        cyc();
        reset = 1'b0; sink_rst = 1'b0;
        // Word offered and an ack glitch arriving during SETTLE.
        bus.io_enq_valid = 1'b1;
        bus.io_enq_bits  = 32'h0000_0077;
        ack_glitch       = 1'b1;
        cyc();
        ack_glitch = 1'b0;
        for (int i = 1; i <= SYNC_DEPTH; i++) begin
            if (i > 1) cyc();
            check_bit("resettle_ready", bus.io_enq_ready, 1'b0);
            check_bit("resettle_req",   bus.io_req,       1'b0);
            check    ("resettle_data",  bus.io_data,      32'h0);
        end
        cyc();
        check_bit("reidle_ready", bus.io_enq_ready, 1'b1);
        check    ("reidle_data",  bus.io_data,      32'h0);
        cyc();
        check_bit("fire77_req",  bus.io_req,  1'b1);
        check    ("fire77_data", bus.io_data, 32'h77);
        bus.io_enq_valid = 1'b0;
        wait_ready(n);
        check    ("gap77",        n,         ACCEPT_GAP);
        check_bit("err_after",    dut.err_q, 1'b0);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_async_handshake_source
